// File: rtl/wb_commit_unit.sv
// Writeback commit stage: selects and extends the result, then updates the GPR file and HI/LO.
// Optional trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_commit_unit #(
  parameter int unsigned RF_DEPTH = 32,
  parameter int unsigned DATA_W   = 32,
  localparam int unsigned AW      = $clog2(RF_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          WB_WbSel,
  input  logic [DATA_W-1:0]   WB_PCAdd1,
  input  logic [DATA_W-1:0]   WB_ALUOut,
  input  logic [DATA_W-1:0]   WB_OutB,
  input  logic [DATA_W-1:0]   WB_DMOut,
  input  logic [AW-1:0]       WB_Dst,
  input  logic [2:0]          WB_LoadType,
  input  logic [2:0]          WB_RegsWrType,
  input  logic [2*DATA_W-1:0] WB_HiLoData,
  input  logic                WB_ExceptValid,
  input  logic [AW-1:0]       RdAddrA,
  input  logic [AW-1:0]       RdAddrB,
  output logic [DATA_W-1:0]   RdDataA,
  output logic [DATA_W-1:0]   RdDataB,
  output logic [DATA_W-1:0]   HiOut,
  output logic [DATA_W-1:0]   LoOut,
  output logic [DATA_W-1:0]   WB_Result,
  output logic                WB_RFWrEn,
  output logic [AW-1:0]       WB_WrDst
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [DATA_W-1:0]   debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [AW-1:0]       debug_wb_rf_wnum,
  output logic [DATA_W-1:0]   debug_wb_rf_wdata
`endif
);

  logic [DATA_W-1:0] r_gpr [RF_DEPTH];
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [1:0]        w_off;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic              w_rfwe;
  logic              w_hiwe;
  logic              w_lowe;
  logic [DATA_W-1:0] w_hi_wdata;
  logic [DATA_W-1:0] w_lo_wdata;

  assign w_off  = WB_ALUOut[1:0];
  assign w_byte = WB_DMOut[{w_off, 3'b000} +: 8];
  // Halfword alignment is enforced upstream, so only off[1] picks the lane.
  assign w_half = WB_DMOut[{w_off[1], 4'b0000} +: 16];

  always_comb begin
    w_load = WB_DMOut;
    unique case (WB_LoadType[1:0])
      2'b01:   w_load = {{(DATA_W-16){WB_LoadType[2] & w_half[15]}}, w_half};
      2'b10:   w_load = {{(DATA_W-8){WB_LoadType[2] & w_byte[7]}}, w_byte};
      default: w_load = WB_DMOut;
    endcase
  end

  always_comb begin
    WB_Result = WB_ALUOut;
    unique case (WB_WbSel)
      2'b00:   WB_Result = WB_ALUOut;
      2'b01:   WB_Result = w_load;
      2'b10:   WB_Result = WB_PCAdd1;
      default: WB_Result = WB_OutB;
    endcase
  end

  assign w_rfwe = WB_RegsWrType[2] & ~WB_ExceptValid & (WB_Dst != '0);
  assign w_hiwe = WB_RegsWrType[1] & ~WB_ExceptValid;
  assign w_lowe = WB_RegsWrType[0] & ~WB_ExceptValid;

  assign WB_RFWrEn = w_rfwe;
  assign WB_WrDst  = w_rfwe ? WB_Dst : '0;

  // Paired write is MULT/DIV; a lone HI or LO write is MTHI/MTLO from the ALU.
  assign w_hi_wdata = w_lowe ? WB_HiLoData[2*DATA_W-1:DATA_W] : WB_ALUOut;
  assign w_lo_wdata = w_hiwe ? WB_HiLoData[DATA_W-1:0] : WB_ALUOut;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RF_DEPTH; i++) begin
        r_gpr[i] <= '0;
      end
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_rfwe) r_gpr[WB_Dst] <= WB_Result;
      if (w_hiwe) r_hi <= w_hi_wdata;
      if (w_lowe) r_lo <= w_lo_wdata;
    end
  end

  always_comb begin
    RdDataA = r_gpr[RdAddrA];
    if (w_rfwe && (RdAddrA == WB_Dst)) RdDataA = WB_Result;
    if (RdAddrA == '0) RdDataA = '0;
    RdDataB = r_gpr[RdAddrB];
    if (w_rfwe && (RdAddrB == WB_Dst)) RdDataB = WB_Result;
    if (RdAddrB == '0) RdDataB = '0;
  end

  assign HiOut = w_hiwe ? w_hi_wdata : r_hi;
  assign LoOut = w_lowe ? w_lo_wdata : r_lo;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = WB_PCAdd1 - DATA_W'(8);
  assign debug_wb_rf_wen   = {4{w_rfwe}};
  assign debug_wb_rf_wnum  = WB_WrDst;
  assign debug_wb_rf_wdata = WB_Result;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Testbench for wb_commit_unit: load-extraction table, directed corner sequences and
// randomized traffic against an architectural reference model.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB_WbSel;
  logic [31:0] WB_PCAdd1, WB_ALUOut, WB_OutB, WB_DMOut;
  logic [4:0]  WB_Dst;
  logic [2:0]  WB_LoadType, WB_RegsWrType;
  logic [63:0] WB_HiLoData;
  logic        WB_ExceptValid;
  logic [4:0]  RdAddrA, RdAddrB;
  logic [31:0] RdDataA, RdDataB, HiOut, LoOut, WB_Result;
  logic        WB_RFWrEn;
  logic [4:0]  WB_WrDst;
`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  wb_commit_unit dut (
    .clk            (clk),
    .rst            (rst),
    .WB_WbSel       (WB_WbSel),
    .WB_PCAdd1      (WB_PCAdd1),
    .WB_ALUOut      (WB_ALUOut),
    .WB_OutB        (WB_OutB),
    .WB_DMOut       (WB_DMOut),
    .WB_Dst         (WB_Dst),
    .WB_LoadType    (WB_LoadType),
    .WB_RegsWrType  (WB_RegsWrType),
    .WB_HiLoData    (WB_HiLoData),
    .WB_ExceptValid (WB_ExceptValid),
    .RdAddrA        (RdAddrA),
    .RdAddrB        (RdAddrB),
    .RdDataA        (RdDataA),
    .RdDataB        (RdDataB),
    .HiOut          (HiOut),
    .LoOut          (LoOut),
    .WB_Result      (WB_Result),
    .WB_RFWrEn      (WB_RFWrEn),
    .WB_WrDst       (WB_WrDst)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural state as seen by software.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_result();
    logic [31:0] v;
    int          width;
    int          off;
    off = int'(WB_ALUOut[1:0]);
    case (WB_LoadType[1:0])
      2'b10:   begin v = (WB_DMOut >> (8 * off)) & 32'hFF;          width = 8;  end
      2'b01:   begin v = (WB_DMOut >> (16 * (off / 2))) & 32'hFFFF; width = 16; end
      default: begin v = WB_DMOut;                                  width = 32; end
    endcase
    if (WB_LoadType[2] && width < 32 && v[width-1]) v = v | ~((32'd1 << width) - 32'd1);
    case (WB_WbSel)
      2'd0:    return WB_ALUOut;
      2'd1:    return v;
      2'd2:    return WB_PCAdd1;
      default: return WB_OutB;
    endcase
  endfunction

  function automatic bit m_rfwe();
    return WB_RegsWrType[2] && !WB_ExceptValid && WB_Dst != 5'd0;
  endfunction
  function automatic bit m_hiwe();
    return WB_RegsWrType[1] && !WB_ExceptValid;
  endfunction
  function automatic bit m_lowe();
    return WB_RegsWrType[0] && !WB_ExceptValid;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (m_rfwe() && a == WB_Dst) return m_result();
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] m_hi_next();
    if (!m_hiwe()) return m_hi;
    return m_lowe() ? WB_HiLoData[63:32] : WB_ALUOut;
  endfunction
  function automatic logic [31:0] m_lo_next();
    if (!m_lowe()) return m_lo;
    return m_hiwe() ? WB_HiLoData[31:0] : WB_ALUOut;
  endfunction

  task automatic bubble();
    WB_WbSel = 2'd0; WB_PCAdd1 = 32'd0; WB_ALUOut = 32'd0; WB_OutB = 32'd0;
    WB_DMOut = 32'd0; WB_Dst = 5'd0; WB_LoadType = 3'd0; WB_RegsWrType = 3'd0;
    WB_HiLoData = 64'd0; WB_ExceptValid = 1'b0;
  endtask

  // Inputs are already applied; check combinational outputs mid-cycle, then commit.
  task automatic cycle();
    #3;
    if (!rst) begin
      chk("WB_Result", WB_Result, m_result());
      chk("WB_RFWrEn", {31'd0, WB_RFWrEn}, {31'd0, m_rfwe()});
      chk("WB_WrDst", {27'd0, WB_WrDst}, m_rfwe() ? {27'd0, WB_Dst} : 32'd0);
      chk("RdDataA", RdDataA, m_read(RdAddrA));
      chk("RdDataB", RdDataB, m_read(RdAddrB));
      chk("HiOut", HiOut, m_hi_next());
      chk("LoOut", LoOut, m_lo_next());
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
      m_hi = 32'd0;
      m_lo = 32'd0;
    end else begin
      logic [31:0] nh, nl;
      nh = m_hi_next();
      nl = m_lo_next();
      if (m_rfwe()) m_gpr[WB_Dst] = m_result();
      m_hi = nh;
      m_lo = nl;
    end
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [2:0]  lt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{2'd1, 32'h0000_0002, 32'h8033_F0AA, 3'b110, 32'h0000_0033};
    vecs[1]  = '{2'd1, 32'h0000_0001, 32'h8033_F0AA, 3'b110, 32'hFFFF_FFF0};
    vecs[2]  = '{2'd1, 32'h0000_0002, 32'h8033_F0AA, 3'b001, 32'h0000_8033};
    vecs[3]  = '{2'd1, 32'h0000_0002, 32'h8033_F0AA, 3'b101, 32'hFFFF_8033};
    vecs[4]  = '{2'd1, 32'h0000_0000, 32'h8033_F0AA, 3'b010, 32'h0000_00AA};
    vecs[5]  = '{2'd1, 32'h0000_0003, 32'h8033_F0AA, 3'b110, 32'hFFFF_FF80};
    vecs[6]  = '{2'd1, 32'h0000_0001, 32'h8033_F0AA, 3'b101, 32'hFFFF_F0AA};
    vecs[7]  = '{2'd1, 32'h0000_0002, 32'h8033_F0AA, 3'b111, 32'h8033_F0AA};
    vecs[8]  = '{2'd0, 32'h1234_0002, 32'h8033_F0AA, 3'b110, 32'h1234_0002};
    vecs[9]  = '{2'd2, 32'h0000_0002, 32'h8033_F0AA, 3'b110, 32'h0040_0008};
    vecs[10] = '{2'd3, 32'h0000_0002, 32'h8033_F0AA, 3'b110, 32'hCAFE_0001};

    bubble();
    RdAddrA = 5'd0; RdAddrB = 5'd0;
    rst = 1'b1;
    @(posedge clk); #1;
    cycle();
    rst = 1'b0;

    // Reset state across all addresses.
    for (int i = 0; i < 32; i += 2) begin
      RdAddrA = 5'(i); RdAddrB = 5'(i + 1);
      cycle();
    end

    // Load-extraction and writeback mux table, each written to r7.
    for (int i = 0; i < 11; i++) begin
      bubble();
      WB_WbSel = vecs[i].sel; WB_ALUOut = vecs[i].alu; WB_DMOut = vecs[i].dm;
      WB_LoadType = vecs[i].lt; WB_PCAdd1 = 32'h0040_0008; WB_OutB = 32'hCAFE_0001;
      WB_Dst = 5'd7; WB_RegsWrType = 3'b100; RdAddrA = 5'd7; RdAddrB = 5'd1;
      #3;
      chk($sformatf("vec%0d_result", i), WB_Result, vecs[i].exp);
      chk($sformatf("vec%0d_bypass", i), RdDataA, vecs[i].exp);
      #1;
      cycle();
      bubble();
      #3;
      chk($sformatf("vec%0d_stored", i), RdDataA, vecs[i].exp);
      #1;
    end

    // Same-cycle bypass on both ports, then persistence.
    bubble();
    WB_ALUOut = 32'h1234_5678; WB_Dst = 5'd9; WB_RegsWrType = 3'b100;
    RdAddrA = 5'd9; RdAddrB = 5'd9;
    #3;
    chk("byp_A", RdDataA, 32'h1234_5678);
    chk("byp_B", RdDataB, 32'h1234_5678);
    #1;
    cycle();
    bubble();
    #3;
    chk("persist_A", RdDataA, 32'h1234_5678);
    chk("persist_B", RdDataB, 32'h1234_5678);
    #1;
    cycle();

    // Write to r0 is squashed.
    WB_ALUOut = 32'hDEAD_BEEF; WB_Dst = 5'd0; WB_RegsWrType = 3'b100;
    RdAddrA = 5'd0;
    #3;
    chk("r0_wen", {31'd0, WB_RFWrEn}, 32'd0);
    chk("r0_read", RdDataA, 32'd0);
    #1;
    cycle();
    bubble();
    cycle();

    // MULT then MTHI.
    WB_RegsWrType = 3'b011; WB_HiLoData = 64'h1_0000_0002;
    cycle();
    bubble();
    #3;
    chk("mult_hi", HiOut, 32'd1);
    chk("mult_lo", LoOut, 32'd2);
    #1;
    WB_RegsWrType = 3'b010; WB_ALUOut = 32'h55;
    #3;
    chk("mthi_bypass", HiOut, 32'h55);
    #1;
    cycle();
    bubble();
    #3;
    chk("mthi_hi", HiOut, 32'h55);
    chk("mthi_lo", LoOut, 32'd2);
    #1;

    // Excepted instruction leaves r4 and HI/LO alone.
    WB_ALUOut = 32'h11; WB_Dst = 5'd4; WB_RegsWrType = 3'b100;
    cycle();
    bubble();
    WB_ALUOut = 32'h99; WB_Dst = 5'd4; WB_RegsWrType = 3'b111;
    WB_HiLoData = 64'hAAAA_AAAA_BBBB_BBBB; WB_ExceptValid = 1'b1; RdAddrA = 5'd4;
    #3;
    chk("exc_wen", {31'd0, WB_RFWrEn}, 32'd0);
    chk("exc_dst", {27'd0, WB_WrDst}, 32'd0);
    chk("exc_read", RdDataA, 32'h11);
    #1;
    cycle();
    bubble();
    #3;
    chk("exc_r4", RdDataA, 32'h11);
    chk("exc_hi", HiOut, 32'h55);
    chk("exc_lo", LoOut, 32'd2);
    #1;

    // Reset wipes r5 and HI after writes.
    WB_ALUOut = 32'h77; WB_Dst = 5'd5; WB_RegsWrType = 3'b110;
    cycle();
    bubble();
    rst = 1'b1;
    WB_ALUOut = 32'h88; WB_Dst = 5'd5; WB_RegsWrType = 3'b111;
    cycle();
    bubble();
    cycle();
    rst = 1'b0;
    RdAddrA = 5'd5;
    #3;
    chk("rst_r5", RdDataA, 32'd0);
    chk("rst_hi", HiOut, 32'd0);
    chk("rst_lo", LoOut, 32'd0);
    #1;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      WB_WbSel       = 2'($urandom_range(0, 3));
      WB_PCAdd1      = $urandom;
      WB_ALUOut      = $urandom;
      WB_OutB        = $urandom;
      WB_DMOut       = $urandom;
      WB_Dst         = 5'($urandom_range(0, 31));
      WB_LoadType    = 3'($urandom_range(0, 7));
      WB_RegsWrType  = 3'($urandom_range(0, 7));
      WB_HiLoData    = {$urandom, $urandom};
      WB_ExceptValid = ($urandom_range(0, 7) == 0);
      RdAddrA        = ($urandom_range(0, 3) == 0) ? WB_Dst : 5'($urandom_range(0, 31));
      RdAddrB        = ($urandom_range(0, 3) == 0) ? RdAddrA : 5'($urandom_range(0, 31));
      rst            = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    bubble();
    for (int i = 0; i < 32; i += 2) begin
      RdAddrA = 5'(i); RdAddrB = 5'(i + 1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Consumer end of the MEM/WB pipeline register. Takes the registered WB-stage bundle and commits it to architectural state.
- Per instruction: selects the writeback value, extracts and extends load data, then writes the 32x32 GPR file and the HI/LO pair.
- Provides bypassed GPR and HI/LO read ports for ID/EX, plus the WB forwarding source.

Parameters:
- RF_DEPTH, 32, number of GPRs; index width is clog2(RF_DEPTH).
- DATA_W, 32, datapath width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- WB_WbSel  in  2  00 ALUOut, 01 load data, 10 PCAdd1 (link), 11 OutB
- WB_PCAdd1  in  32  link address, equal to PC+8
- WB_ALUOut  in  32  ALU result; bits [1:0] are the load byte offset
- WB_OutB  in  32  rt operand
- WB_DMOut  in  32  raw data-memory word
- WB_Dst  in  5  GPR destination
- WB_LoadType  in  3  [2] sign-extend, [1:0] size: 00 word, 01 half, 10 byte, 11 treated as word
- WB_RegsWrType  in  3  [2] RFWr, [1] HIWr, [0] LOWr
- WB_HiLoData  in  64  MULT/DIV result as {hi,lo}
- WB_ExceptValid  in  1  instruction excepted; suppresses every write
- RdAddrA, RdAddrB  in  5  GPR read addresses
- RdDataA, RdDataB  out  32  bypassed GPR read data
- HiOut, LoOut  out  32  bypassed HI/LO read data
- WB_Result  out  32  selected writeback value, for forwarding
- WB_RFWrEn  out  1  effective GPR write enable
- WB_WrDst  out  5  effective destination; 0 when WB_RFWrEn=0

Behaviour:
- Reset: on a posedge with rst=1, all GPRs, HI and LO are cleared to 0. All outputs are combinational over cleared state.
  - Pending writes in that cycle are dropped.
  - Reset during any operation behaves the same way; no partial writes occur.
- Load extraction, from WB_DMOut at offset off = WB_ALUOut[1:0], little-endian:
  - Byte: DMOut[8*off+7 : 8*off].
  - Half: DMOut[16*off[1]+15 : 16*off[1]]; off[0] is ignored, since alignment is checked in MEM.
  - Word: DMOut unchanged.
  - Extension: sign-extend if LoadType[2]=1, else zero-extend.
- WB_Result is a mux of WB_WbSel over {ALUOut, extended load, PCAdd1, OutB}. It is purely combinational.
- Effective enables:
  - rfwe = RFWr & !ExceptValid & (Dst != 0).
  - hiwe = HIWr & !ExceptValid.
  - lowe = LOWr & !ExceptValid.
- GPR write: at posedge, when rfwe, GPR[Dst] <= WB_Result.
  - GPR[0] always reads 0 and is never written.
- HI/LO writes at posedge:
  - hiwe & lowe: {HI,LO} <= WB_HiLoData (MULT/DIV).
  - hiwe only: HI <= WB_ALUOut (MTHI).
  - lowe only: LO <= WB_ALUOut (MTLO).
- Read ports are combinational with zero-latency bypass:
  - If rfwe and RdAddrX == Dst, RdDataX = WB_Result; otherwise GPR[RdAddrX].
  - RdAddrX == 0 always returns 0, even if a write to 0 is in flight.
  - HiOut/LoOut return the value being written this cycle when hiwe/lowe is set; otherwise the stored register.
  - Bypass resolves simultaneous write and read to the same entry.
- Both read ports may address the same register; each is independent.
- Excepted instruction: no GPR or HI/LO state change, WB_RFWrEn=0, WB_WrDst=0. WB_Result still reflects the mux.
- Writes commit with 1-cycle latency into storage. Combined with the bypass, read-after-write is visible in the same cycle.
- No stall input: the MEM/WB register inserts bubbles as all-zero bundles, which are no-ops here.

Optional Feature:
- Macro: WB_DEBUG_TRACE_EN.
- When defined, adds these outputs for trace comparison:
  - debug_wb_pc (32) = WB_PCAdd1 - 8.
  - debug_wb_rf_wen (4) = {4{rfwe}}.
  - debug_wb_rf_wnum (5) = WB_WrDst.
  - debug_wb_rf_wdata (32) = WB_Result.
- When undefined, these ports and their logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Reset: assert rst for 2 cycles after writes to r5 and HI. Then RdAddrA=5 -> 0, and HiOut=0, LoOut=0.
- LB with sign extend: DMOut=0x8033_F0AA, ALUOut[1:0]=2, LoadType=3'b110, WbSel=01, Dst=7, RFWr=1.
  - Required: WB_Result=0x0000_0033 and r7=0x33 next cycle.
  - With off=1: 0xFFFF_FFF0.
  - LHU with off=2: 0x0000_8033.
- Bypass: write r9 = ALUOut 0x1234_5678 while RdAddrA=RdAddrB=9. Both ports show 0x1234_5678 in the same cycle, and the value persists afterward.
- Zero register: RFWr=1, Dst=0, ALUOut=0xDEAD_BEEF. WB_RFWrEn=0, RdAddrA=0 returns 0.
- HI/LO:
  - RegsWrType=011 with HiLoData=0x1_0000_0002 -> HI=1, LO=2.
  - Then 010 with ALUOut=0x55 -> HI=0x55, LO stays 2. HiOut shows 0x55 during the write cycle.
- Exception: RegsWrType=111, ExceptValid=1, Dst=4, with r4 previously 0x11. r4 stays 0x11, HI/LO unchanged, and WB_RFWrEn=0.
